// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: a circular FIFO that sits in front of the UART transmitter.
// Producers can write bursts of bytes at clock rate. A two-state launch FSM
// sends the bytes out one at a time using the tx_start / tx_done_tick
// handshake, so only one frame is ever in flight.
module uart_tx_buffer #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              reset,
    input  logic              i_wr,
    input  logic [DBIT-1:0]   i_wdata,
    input  logic              i_tx_done_tick,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              tx_start_q, tx_start_d;
    logic [DBIT-1:0]   tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;

    logic full;
    logic empty;
    logic wr_accept;
    logic pop;

    // The flags depend only on the registered count, so i_wr has no
    // combinational path to them.
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign wr_accept = i_wr && !full;

    // Launch FSM: in IDLE, pop the head when data is waiting. In BUSY, wait
    // for the transmitter's done tick.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (i_tx_done_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer, occupancy and sticky-overflow update. A write that arrives
    // while the FIFO is full leaves storage untouched and only records the
    // overflow.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (i_wr & full);
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control and output registers. An asynchronous reset clears them, which
    // discards any buffered bytes and abandons a frame in flight.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage. This array has no reset; the pointers alone decide which
    // entries are valid.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer. A queue-based reference model predicts the
// outputs on every cycle. Directed scenarios are followed by a randomized
// burst phase.
module tb_uart_tx_buffer;

    logic       i_clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_wdata = '0;
    logic       i_tx_done_tick = 1'b0;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;

    uart_tx_buffer #(.DBIT(8), .ADDR_W(4)) dut (
        .i_clk          (i_clk),
        .reset          (reset),
        .i_wr           (i_wr),
        .i_wdata        (i_wdata),
        .i_tx_done_tick (i_tx_done_tick),
        .o_tx_start     (o_tx_start),
        .o_tx_data      (o_tx_data),
        .o_full         (o_full),
        .o_empty        (o_empty),
        .o_count        (o_count),
        .o_overflow     (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: the byte queue, whether one frame is outstanding,
    // and the expected registered outputs.
    logic [7:0] mq[$];
    bit         m_busy;
    bit         m_ovf;
    bit         m_start;
    logic [7:0] m_data;

    logic [7:0] lq[$];          // bytes the DUT launched, recorded in order
    int n_assert = 0;
    int n_fail   = 0;
    int step_no  = 0;
    int last_done_step = 0;
    int tx_cnt   = 0;
    int tx_dly   = 0;           // 0 means a random delay from 1 to 8
    bit tx_auto  = 1'b0;
    bit spurious = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("tx_start", 32'(o_tx_start), 32'(m_start));
        chk("tx_data",  32'(o_tx_data),  32'(m_data));
        chk("count",    32'(o_count),    mq.size());
        chk("empty",    32'(o_empty),    32'(mq.size() == 0));
        chk("full",     32'(o_full),     32'(mq.size() == 16));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_start = 1'b0;
        m_data  = 8'h00;
        tx_cnt  = 0;
    endtask

    // Run one clock cycle: drive the inputs, advance the model at the edge,
    // then compare just after the edge.
    task automatic cycle(input bit wr, input logic [7:0] d, input bit done);
        bit dn;
        bit full_pre;
        dn = tx_auto ? (tx_cnt == 1) : done;
        if (spurious && tx_cnt == 0 && $urandom_range(15, 0) == 0) dn = 1'b1;
        if (tx_cnt > 0) tx_cnt--;
        i_wr = wr;
        i_wdata = d;
        i_tx_done_tick = dn;
        @(posedge i_clk);
        full_pre = (mq.size() == 16);
        m_start = 1'b0;
        if (!m_busy && mq.size() != 0) begin
            m_data  = mq.pop_front();
            m_start = 1'b1;
            m_busy  = 1'b1;
        end else if (m_busy && dn) begin
            m_busy = 1'b0;
        end
        if (wr) begin
            if (full_pre) m_ovf = 1'b1;
            else          mq.push_back(d);
        end
        #1;
        check_outputs();
        if (dn) last_done_step = step_no;
        if (o_tx_start) begin
            lq.push_back(o_tx_data);
            tx_cnt = (tx_dly == 0) ? int'($urandom_range(8, 1)) : tx_dly;
        end
        step_no++;
        i_wr = 1'b0;
        i_tx_done_tick = 1'b0;
    endtask

    task automatic apply_reset();
        i_wr = 1'b0;
        i_tx_done_tick = 1'b0;
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs();
        @(posedge i_clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    // Drain with a done tick every third cycle.
    task automatic drain(input int frames);
        for (int k = 0; k < frames; k++) begin
            cycle(1'b0, 8'h00, 1'b1);
            cycle(1'b0, 8'h00, 1'b0);
            cycle(1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nstart;
        logic [7:0] v;
        model_reset();
        #3;
        apply_reset();

        // A single byte launches one cycle after it is accepted.
        cycle(1'b1, 8'hA5, 1'b0);
        chk("a5_count1", 32'(o_count), 32'd1);
        chk("a5_nostart", 32'(o_tx_start), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("a5_start", 32'(o_tx_start), 32'd1);
        chk("a5_data", 32'(o_tx_data), 32'hA5);
        chk("a5_empty", 32'(o_empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("a5_pulse1", 32'(o_tx_start), 32'd0);
        cycle(1'b0, 8'h00, 1'b1);

        // Three bytes go out back to back through a transmitter that takes
        // 20 cycles per frame.
        lq.delete();
        tx_auto = 1'b1;
        tx_dly = 20;
        nstart = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(i < 3, 8'(i + 1), 1'b0);
            if (o_tx_start) begin
                if (nstart > 0) chk("b2b_gap", step_no - 1 - last_done_step, 1);
                nstart++;
            end
        end
        tx_auto = 1'b0;
        tx_dly = 0;
        chk("b2b_n", lq.size(), 3);
        for (int i = 0; i < 3 && i < lq.size(); i++) chk("b2b_order", 32'(lq[i]), i + 1);

        // Overflow: with done withheld, 0x10 launches, 0x11..0x20 fill the
        // FIFO, and 0x21 is dropped.
        apply_reset();
        lq.delete();
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
        chk("ovf_full", 32'(o_full), 32'd1);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_count", 32'(o_count), 32'd16);
        drain(18);
        chk("ovf_n", lq.size(), 17);
        for (int i = 0; i < 17 && i < lq.size(); i++) chk("ovf_order", 32'(lq[i]), 8'h10 + i);
        chk("ovf_sticky", 32'(o_overflow), 32'd1);

        // A write on the same edge as a pop leaves the count unchanged.
        apply_reset();
        lq.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        chk("wp_count_pre", 32'(o_count), 32'd3);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h34, 1'b0);
        chk("wp_count", 32'(o_count), 32'd3);
        chk("wp_start", 32'(o_tx_start), 32'd1);
        drain(5);
        chk("wp_n", lq.size(), 5);
        for (int i = 0; i < 5 && i < lq.size(); i++) chk("wp_order", 32'(lq[i]), 8'h30 + i);

        // A done tick while idle and empty has no effect.
        cycle(1'b0, 8'h00, 1'b1);
        chk("idle_done_start", 32'(o_tx_start), 32'd0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("idle_done_start2", 32'(o_tx_start), 32'd0);
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("idle_then_launch", 32'(o_tx_start), 32'd1);
        chk("idle_then_data", 32'(o_tx_data), 32'h55);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset while BUSY with 5 bytes buffered; a later done tick must not
        // launch anything.
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        chk("rb_count", 32'(o_count), 32'd5);
        apply_reset();
        chk("rb_rst_count", 32'(o_count), 32'd0);
        chk("rb_rst_data", 32'(o_tx_data), 32'd0);
        chk("rb_rst_empty", 32'(o_empty), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        chk("rb_no_launch", 32'(o_tx_start), 32'd0);

        // Randomized bursts, random transmitter latency and spurious done
        // ticks while idle.
        apply_reset();
        tx_auto = 1'b1;
        spurious = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 100; i++) begin
                v = 8'($urandom);
                cycle($urandom_range(99, 0) < ((seg % 2 == 0) ? 85 : 15), v, 1'b0);
            end
        end
        for (int i = 0; i < 200; i++) cycle(1'b0, 8'h00, 1'b0);
        spurious = 1'b0;
        tx_auto = 1'b0;
        chk("rand_drained", 32'(o_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
